// File: rtl/fir_output_requant.sv
// Requantizer for FIR accumulator results: round-half-up, shift, saturate, then buffer in a show-ahead FIFO.
// Optional saturation event counter enabled by defining FIR_REQUANT_SAT_COUNT_EN.
module fir_output_requant #(
   parameter int ACC_WIDTH  = 40,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ACC_WIDTH-1:0]          acc_in,
   input  logic                          acc_in_valid,
   output logic [OUT_WIDTH-1:0]          data_out,
   output logic                          data_out_valid,
   input  logic                          data_out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          sat_pulse,
   output logic                          overflow
`ifdef FIR_REQUANT_SAT_COUNT_EN
   ,
   input  logic                          sat_count_clr,
   output logic [15:0]                   sat_count
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int RW    = ACC_WIDTH + 1;

   localparam logic signed [RW-1:0] RND   = RW'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

   logic                 s1_valid_q, s1_valid_d;
   logic signed [RW-1:0] s1_r_q, s1_r_d;
   logic                 sat_pulse_q, sat_pulse_d;
   logic                 overflow_q, overflow_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [OUT_WIDTH-1:0] mem_d [FIFO_DEPTH];

   logic signed [RW-1:0] sum;
   logic                 sat_hi, sat_lo;
   logic [OUT_WIDTH-1:0] clamped;
   logic                 empty, full, push, pop, push_ok;

   always_comb begin
      // one extra bit of headroom keeps the rounding add from wrapping at +max
      sum        = $signed({acc_in[ACC_WIDTH-1], acc_in}) + RND;
      s1_r_d     = sum >>> SHIFT;
      s1_valid_d = acc_in_valid;

      sat_hi  = s1_r_q > MAX_V;
      sat_lo  = s1_r_q < MIN_V;
      clamped = s1_r_q[OUT_WIDTH-1:0];
      if (sat_hi) begin
         clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else if (sat_lo) begin
         clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end

      empty   = (level_q == '0);
      full    = (level_q == LVL_W'(FIFO_DEPTH));
      push    = s1_valid_q;
      pop     = !empty && data_out_ready;
      // at full a simultaneous pop frees the slot the write pointer lands on
      push_ok = push && (!full || pop);

      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = clamped;
      end
      wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      level_d     = level_q + LVL_W'(push_ok) - LVL_W'(pop);
      overflow_d  = overflow_q | (push && full && !pop);
      sat_pulse_d = push && (sat_hi || sat_lo);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_r_q      <= '0;
         sat_pulse_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_r_q      <= s1_r_d;
         sat_pulse_q <= sat_pulse_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         mem_q       <= mem_d;
      end
   end

   assign data_out_valid = !empty;
   assign data_out       = empty ? '0 : mem_q[rd_ptr_q];
   assign fifo_level     = level_q;
   assign sat_pulse      = sat_pulse_q;
   assign overflow       = overflow_q;

`ifdef FIR_REQUANT_SAT_COUNT_EN
   logic [15:0] sat_count_q, sat_count_d;

   always_comb begin
      sat_count_d = sat_count_q;
      if (sat_count_clr) begin
         sat_count_d = '0;
      end else if (sat_pulse_q && (sat_count_q != 16'hFFFF)) begin
         sat_count_d = sat_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count_q <= '0;
      end else begin
         sat_count_q <= sat_count_d;
      end
   end

   assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_fir_output_requant.sv
// Directed and random checks of fir_output_requant against a transaction-level model:
// a queue of expected samples plus one pending stage-1 result.
module tb_fir_output_requant;

   localparam int AW = 40;
   localparam int OW = 16;
   localparam int SH = 15;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] acc_in = '0;
   logic          acc_in_valid = 1'b0;
   logic          data_out_ready = 1'b0;
   logic [OW-1:0] data_out;
   logic          data_out_valid;
   logic [2:0]    fifo_level;
   logic          sat_pulse;
   logic          overflow;
   logic          clr_r = 1'b0;
`ifdef FIR_REQUANT_SAT_COUNT_EN
   logic [15:0]   sat_count;
`endif

   fir_output_requant #(
      .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .acc_in(acc_in),
      .acc_in_valid(acc_in_valid),
      .data_out(data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .fifo_level(fifo_level),
      .sat_pulse(sat_pulse),
      .overflow(overflow)
`ifdef FIR_REQUANT_SAT_COUNT_EN
      ,
      .sat_count_clr(clr_r),
      .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int q[$];
   bit pv = 1'b0;
   int pval = 0;
   bit psat = 1'b0;
   bit ovf_m = 1'b0;
   bit satp_m = 1'b0;
   int satcnt_m = 0;

   function automatic void requant(input longint a, output int v, output bit s);
      longint r;
      r = (a + (64'sd1 <<< (SH - 1))) >>> SH;
      if (r > 32767) begin
         v = 32767; s = 1'b1;
      end else if (r < -32768) begin
         v = -32768; s = 1'b1;
      end else begin
         v = int'(r); s = 1'b0;
      end
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("valid", $signed({1'b0, data_out_valid}), (q.size() > 0) ? 64'sd1 : 64'sd0);
      chk("data", $signed(data_out), (q.size() > 0) ? 64'(q[0]) : 64'sd0);
      chk("level", $signed({1'b0, fifo_level}), 64'(q.size()));
      chk("sat_pulse", $signed({1'b0, sat_pulse}), 64'(satp_m));
      chk("overflow", $signed({1'b0, overflow}), 64'(ovf_m));
`ifdef FIR_REQUANT_SAT_COUNT_EN
      chk("sat_count", $signed({1'b0, sat_count}), 64'(satcnt_m));
`endif
   endtask

   // One clock: drive inputs, advance the model across the edge, then compare.
   task automatic cycle(input bit v, input longint a, input bit r, input bit do_rst);
      bit pop;
      rst = do_rst;
      acc_in_valid = v;
      acc_in = a[AW-1:0];
      data_out_ready = r;
      @(posedge clk);
      if (do_rst) begin
         q.delete();
         pv = 1'b0; ovf_m = 1'b0; satp_m = 1'b0; satcnt_m = 0;
      end else begin
         pop = (q.size() > 0) && r;
         if (clr_r) satcnt_m = 0;
         else if (satp_m && satcnt_m < 65535) satcnt_m++;
         if (pop) void'(q.pop_front());
         satp_m = pv && psat;
         if (pv) begin
            if (q.size() < D) q.push_back(pval);
            else ovf_m = 1'b1;
         end
         if (v) requant(a, pval, psat);
         pv = v;
      end
      #1;
      check_all();
   endtask

   longint rvals[5] = '{64'sd16384, 64'sd16383, -64'sd16384, -64'sd16385, -64'sd98304};
   int     rexp[5]  = '{1, 0, 0, -1, -3};
   longint svals[3] = '{64'sd1 <<< 31, -(64'sd1 <<< 31), (64'sd1 <<< 39) - 1};
   int     sexp[3]  = '{32767, -32768, 32767};

   initial begin
      longint x;
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("rst_valid", $signed({1'b0, data_out_valid}), 64'sd0);
      chk("rst_data", $signed(data_out), 64'sd0);

      // unity and two-clock latency
      cycle(1, 98304, 1, 0);
      chk("lat_early", $signed({1'b0, data_out_valid}), 64'sd0);
      cycle(0, 0, 1, 0);
      chk("lat_valid", $signed({1'b0, data_out_valid}), 64'sd1);
      chk("lat_data", $signed(data_out), 64'sd3);
      cycle(0, 0, 1, 0);
      chk("lat_level", $signed({1'b0, fifo_level}), 64'sd0);

      // rounding boundaries
      for (int i = 0; i < 5; i++) begin
         cycle(1, rvals[i], 1, 0);
         cycle(0, 0, 1, 0);
         chk("round", $signed(data_out), 64'(rexp[i]));
         chk("round_sat", $signed({1'b0, sat_pulse}), 64'sd0);
         cycle(0, 0, 1, 0);
      end

      // saturation
      for (int i = 0; i < 3; i++) begin
         cycle(1, svals[i], 1, 0);
         cycle(0, 0, 1, 0);
         chk("sat_data", $signed(data_out), 64'(sexp[i]));
         chk("sat_pulse_hi", $signed({1'b0, sat_pulse}), 64'sd1);
         cycle(0, 0, 1, 0);
         chk("sat_pulse_lo", $signed({1'b0, sat_pulse}), 64'sd0);
      end

      // backpressure with overflow
      for (int k = 1; k <= 5; k++) cycle(1, 64'(k) * 32768, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      chk("bp_level", $signed({1'b0, fifo_level}), 64'sd4);
      chk("bp_ovf", $signed({1'b0, overflow}), 64'sd1);
      for (int k = 1; k <= 4; k++) begin
         chk("bp_order", $signed(data_out), 64'(k));
         cycle(0, 0, 1, 0);
      end
      chk("bp_empty", $signed({1'b0, data_out_valid}), 64'sd0);

      // full with simultaneous pop
      cycle(0, 0, 0, 1);
      for (int k = 1; k <= 5; k++) cycle(1, 64'(k) * 32768, 0, 0);
      chk("fp_full", $signed({1'b0, fifo_level}), 64'sd4);
      cycle(0, 0, 1, 0);
      chk("fp_level", $signed({1'b0, fifo_level}), 64'sd4);
      chk("fp_ovf", $signed({1'b0, overflow}), 64'sd0);
      for (int k = 2; k <= 5; k++) begin
         chk("fp_order", $signed(data_out), 64'(k));
         cycle(0, 0, 1, 0);
      end

      // reset mid-operation
      for (int k = 1; k <= 4; k++) cycle(1, 64'(k) * 32768, 0, 0);
      chk("mr_level3", $signed({1'b0, fifo_level}), 64'sd3);
      cycle(0, 0, 0, 1);
      chk("mr_valid", $signed({1'b0, data_out_valid}), 64'sd0);
      chk("mr_level", $signed({1'b0, fifo_level}), 64'sd0);
      chk("mr_ovf", $signed({1'b0, overflow}), 64'sd0);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 1, 0);
         chk("mr_gone", $signed({1'b0, data_out_valid}), 64'sd0);
      end

`ifdef FIR_REQUANT_SAT_COUNT_EN
      for (int k = 0; k < 3; k++) cycle(1, 64'sd1 <<< 35, 1, 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0);
      chk("satcnt3", $signed({1'b0, sat_count}), 64'sd3);
      clr_r = 1'b1;
      cycle(0, 0, 1, 0);
      clr_r = 1'b0;
      chk("satcnt_clr", $signed({1'b0, sat_count}), 64'sd0);
`endif

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         x = longint'({$urandom(), $urandom()});
         x = x >>> $urandom_range(24, 58);
         clr_r = ($urandom_range(0, 31) == 0);
         cycle(bit'($urandom_range(0, 1)), x, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
      end
      clr_r = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
